// File: rtl/frame_reader.sv
// frame_reader: raster-scans a framebuffer once per start request and streams
// the pixels out over a valid/ready interface through a 2-entry output FIFO.
// Reads are throttled so that buffered plus in-flight data never exceeds the
// FIFO depth, which keeps full throughput while never dropping read data.
module frame_reader #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        frame_done,
    output logic        mem_rd_en,
    output logic [9:0]  mem_x,
    output logic [8:0]  mem_y,
    input  logic [23:0] mem_rdata,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [7:0]  pix_red,
    output logic [7:0]  pix_green,
    output logic [7:0]  pix_blue,
    output logic        pix_eol,
    output logic        pix_last
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [9:0] X_LAST = 10'(SCREEN_WIDTH - 1);
    localparam logic [8:0] Y_LAST = 9'(SCREEN_HEIGHT - 1);

    // FIFO entry layout: {x[44:35], y[34:26], rgb[25:2], eol[1], last[0]}
    localparam int ENTRY_W = 45;

    logic [1:0]         r_state;
    logic [9:0]         r_x;
    logic [8:0]         r_y;
    logic               r_inflight;
    logic [9:0]         r_rd_x;
    logic [8:0]         r_rd_y;
    logic               r_rd_eol;
    logic               r_rd_last;
    logic [ENTRY_W-1:0] r_fifo [0:1];
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic [1:0]         r_count;
    logic               r_frame_done;

    logic               w_valid;
    logic               w_pop;
    logic [2:0]         w_level;
    logic               w_rd_en;
    logic               w_addr_eol;
    logic               w_addr_last;
    logic [ENTRY_W-1:0] w_head;

    assign w_valid     = (r_count != 2'd0);
    assign w_pop       = w_valid & pix_ready;
    assign w_addr_eol  = (r_x == X_LAST);
    assign w_addr_last = w_addr_eol & (r_y == Y_LAST);
    assign w_head      = w_valid ? r_fifo[r_rd_ptr] : '0;

    // Projected occupancy after this edge, excluding a read issued now; pop is
    // counted so a draining FIFO keeps the read stream running without bubbles.
    assign w_level = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_rd_en = (r_state == ST_READ) && (w_level < 3'd2);

    assign busy       = (r_state == ST_READ) || (r_state == ST_DONE);
    assign frame_done = r_frame_done;
    assign mem_rd_en  = w_rd_en;
    assign mem_x      = r_x;
    assign mem_y      = r_y;
    assign pix_valid  = w_valid;
    assign pix_x      = w_head[44:35];
    assign pix_y      = w_head[34:26];
    assign pix_red    = w_head[25:18];
    assign pix_green  = w_head[17:10];
    assign pix_blue   = w_head[9:2];
    assign pix_eol    = w_head[1];
    assign pix_last   = w_head[0];

    // Control FSM: one frame per start; DONE is held through the frame_done
    // cycle so a start coinciding with frame_done is not taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (start) r_state <= ST_READ;
                ST_READ: if (w_rd_en && w_addr_last) r_state <= ST_DONE;
                ST_DONE: if (r_frame_done) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Raster address counter; returns to (0,0) once the last address is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_rd_en) begin
            if (w_addr_last) begin
                r_x <= '0;
                r_y <= '0;
            end else if (w_addr_eol) begin
                r_x <= '0;
                r_y <= r_y + 9'd1;
            end else begin
                r_x <= r_x + 10'd1;
            end
        end
    end

    // Tag of the read in flight, paired with mem_rdata on the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
            r_rd_x     <= '0;
            r_rd_y     <= '0;
            r_rd_eol   <= 1'b0;
            r_rd_last  <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            if (w_rd_en) begin
                r_rd_x    <= r_x;
                r_rd_y    <= r_y;
                r_rd_eol  <= w_addr_eol;
                r_rd_last <= w_addr_last;
            end
        end
    end

    // Output FIFO: capture returning read data, pop on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_fifo[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (r_inflight) begin
                r_fifo[r_wr_ptr] <= {r_rd_x, r_rd_y, mem_rdata, r_rd_eol, r_rd_last};
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

    // frame_done pulses in the cycle after the last pixel is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_pop & w_head[0];
        end
    end

endmodule
